// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one word-addressed memory between the program
// loader (LD), the MEM-stage data port (DM) and the IF-stage fetch port (IF).
// Fixed priority LD > DM > IF, except that IF is promoted over DM after
// STARVE_MAX consecutive DM grants made while fetch was waiting. An access
// the memory never acknowledges is aborted after TIMEOUT cycles. The abort
// returns 32'hDEADBEEF to the reader and sets a sticky err flag.
module cpu_mem_arbiter #(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  // data port
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_ready,
  // loader port (write-only)
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_ready,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);
  localparam logic [SCW-1:0] STV_MAX  = SCW'(STARVE_MAX);
  localparam logic [31:0]    DEAD     = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {W_IF, W_DM, W_LD} win_e;

  state_e          state_q,   state_d;
  win_e            win_q,     win_d;
  logic            mem_en_q,  mem_en_d;
  logic            mem_we_q,  mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     dm_rdata_q, dm_rdata_d;
  logic            if_ready_q, if_ready_d;
  logic            dm_ready_q, dm_ready_d;
  logic            ld_ready_q, ld_ready_d;
  logic            err_q,     err_d;
  logic [TCW-1:0]  tmo_q,     tmo_d;
  logic [SCW-1:0]  starve_q,  starve_d;

  // arbitration decision, only acted on in IDLE
  logic if_promote, grant_ld, grant_dm, grant_if;

  // pick the winner: LD first, then DM unless fetch has been starved long enough
  always_comb begin
    if_promote = if_req && (starve_q == STV_MAX);
    grant_ld   = ld_req;
    grant_dm   = !ld_req && dm_req && !if_promote;
    grant_if   = !ld_req && if_req && (!dm_req || if_promote);
  end

  // next-state and next-output computation for the access sequencer
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    ld_ready_d  = 1'b0;
    err_d       = err_q;
    tmo_d       = tmo_q;
    starve_d    = starve_q;

    case (state_q)
      IDLE: begin
        // fetch starvation tracking; the counter saturates at STARVE_MAX
        if (!if_req || grant_if)
          starve_d = '0;
        else if (grant_dm && starve_q != STV_MAX)
          starve_d = starve_q + 1'b1;

        if (grant_ld || grant_dm || grant_if) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          tmo_d    = '0;
          if (grant_ld) begin
            win_d       = W_LD;
            mem_we_d    = 1'b1;
            mem_addr_d  = ld_addr;
            mem_wdata_d = ld_wdata;
          end else if (grant_dm) begin
            win_d       = W_DM;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            win_d       = W_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end

      ACCESS: begin
        // ack and timeout both finish the access; ack takes precedence
        if (mem_ack || tmo_q == TMO_LAST) begin
          state_d  = RESP;
          mem_en_d = 1'b0;
          if (!mem_ack) err_d = 1'b1;
          if (!mem_we_q) begin
            if (win_q == W_IF) if_rdata_d = mem_ack ? mem_rdata : DEAD;
            if (win_q == W_DM) dm_rdata_d = mem_ack ? mem_rdata : DEAD;
          end
          // the ready flop is set here so it is high for the RESP cycle
          if_ready_d = (win_q == W_IF);
          dm_ready_d = (win_q == W_DM);
          ld_ready_d = (win_q == W_LD);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // state register; reset drops any in-flight access without a ready pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      win_q       <= W_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      ld_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      ld_ready_q  <= ld_ready_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      starve_q    <= starve_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign ld_ready  = ld_ready_q;
  assign err       = err_q;

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Single-port memory arbiter for the 5-stage CPU, replacing separate imem/dmem arrays with one unified word-addressed memory. It shares that memory between three requesters: the program loader (LD), the MEM-stage data port (DM) and the IF-stage fetch port (IF). Requesters use level req/ready handshakes; the memory side uses an en/ack handshake. The block adds starvation protection for fetch and a timeout error for accesses the memory never acknowledges.

Parameters:
AW, 10, word-address width for all address ports.
STARVE_MAX, 4, consecutive DM grants made while if_req is high before IF is promoted over DM.
TIMEOUT, 16, cycles in ACCESS without mem_ack before the access is aborted.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, level
if_addr  in  AW  fetch word address
if_rdata  out  32  fetch read data, valid while if_ready=1
if_ready  out  1  one-cycle completion pulse for IF
dm_req  in  1  data request, level
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data word address
dm_wdata  in  32  store data
dm_rdata  out  32  load data, valid while dm_ready=1
dm_ready  out  1  one-cycle completion pulse for DM
ld_req  in  1  loader write request, level (write-only port)
ld_addr  in  AW  loader word address
ld_wdata  in  32  loader write data
ld_ready  out  1  one-cycle completion pulse for LD
mem_en  out  1  memory command valid
mem_we  out  1  memory write enable
mem_addr  out  AW  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, sampled when mem_ack=1
mem_ack  in  1  memory completion, single cycle
err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, all readies, if_rdata, dm_rdata, err.
  - Starvation counter and timeout counter clear.
  - An in-flight access is dropped. No ready pulse is issued for it.
- Requester rules:
  - A requester holds req, address and data stable from assertion until its ready pulse.
  - A requester may deassert or re-request in the cycle after its ready pulse.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, choose a winner and register the winner id plus mem_we/mem_addr/mem_wdata.
  - Assert mem_en and go to ACCESS.
  - mem_we is 1 for LD, dm_we for DM, 0 for IF.
  - mem_wdata is 0 for IF.
- ACCESS:
  - mem_en and the command fields are held constant.
  - The timeout counter increments each cycle.
  - When mem_ack=1: capture mem_rdata into the winner's rdata register (IF or DM reads only), drop mem_en, go to RESP.
  - When the counter reaches TIMEOUT with no ack: drop mem_en, load the winner's rdata with 32'hDEADBEEF (IF/DM), set err=1, go to RESP.
  - mem_ack seen in IDLE or RESP is ignored.
- RESP:
  - Pulse the winner's ready for exactly one cycle, then go to IDLE.
  - Arbitration in that IDLE cycle sees updated req levels.
  - Minimum latency: request sampled in cycle N, mem_ack in N+1, ready in N+2, next grant in N+3.
- Priority: LD > DM > IF, with one exception.
  - The starvation counter increments on each DM grant made while if_req=1.
  - It clears when IF is granted or when if_req=0 at arbitration.
  - When the counter equals STARVE_MAX and both if_req and dm_req are high, IF wins over DM. LD still wins over both.
  - The counter saturates at STARVE_MAX.
- rdata registers hold their last value between transactions.
- Writes never update any rdata register.
- err clears only on reset.

Test Plan:
1. Fetch read:
   - Stimulus: if_req=1, if_addr=0; memory acks one cycle after mem_en with rdata 32'h00221800.
   - Response: mem_en=1, mem_we=0, mem_addr=0 for 1 cycle; if_ready pulses 2 cycles after the request is sampled; if_rdata=32'h00221800; dm_ready and ld_ready stay 0.
2. DM beats IF:
   - Stimulus: if_req and dm_req (load, addr 1, mem data 32'd100) assert in the same cycle.
   - Response: DM is served first with dm_rdata=100; IF is granted in the IDLE cycle after dm_ready.
3. Starvation, STARVE_MAX=2:
   - Stimulus: dm_req held high continuously; if_req held high.
   - Response: grant order is DM, DM, IF, DM, DM, IF.
4. Loader priority:
   - Stimulus: ld_req (addr 2, data 32'h8CA60004) and dm_req in the same cycle.
   - Response: mem_we=1, mem_addr=2, mem_wdata=32'h8CA60004; ld_ready pulses; DM is served next.
5. Timeout, TIMEOUT=8:
   - Stimulus: DM load; mem_ack is never asserted.
   - Response: mem_en is high for 8 cycles; then dm_ready=1 with dm_rdata=32'hDEADBEEF; err=1 and stays 1 through later good accesses.
6. Reset mid-access:
   - Stimulus: reset driven to 0 while in ACCESS.
   - Response: mem_en drops to 0 immediately with no clock edge; no ready pulse occurs; after release, a pending if_req is granted normally.
